car_scheduler: RTL and testbench
================================

CAR_SCHEDULER -- requirements
Module: car_scheduler

Interface
REQ-001 SHALL have parameter BUTTONS_WIDTH, default 8, number of levels served.
REQ-002 SHALL have parameter TRAVEL_CYCLES, default 16, clock cycles to move one level.
REQ-003 SHALL have parameter DOOR_CYCLES, default 32, clock cycles doors stay open.
REQ-004 SHALL have port clk input 1: the single clock; all state changes occur on its rising edge.
REQ-005 SHALL have port reset input 1: asynchronous, active-high reset.
REQ-006 SHALL have port active_in_levels input BUTTONS_WIDTH: latched car calls, one bit per level.
REQ-007 SHALL have port active_out_up_levels input BUTTONS_WIDTH: latched up hall calls.
REQ-008 SHALL have port active_out_down_levels input BUTTONS_WIDTH: latched down hall calls.
REQ-009 SHALL have port inactivate_in_levels output BUTTONS_WIDTH: one-cycle pulse that clears a served car call.
REQ-010 SHALL have ports inactivate_out_up_levels and inactivate_out_down_levels, each output BUTTONS_WIDTH: one-cycle clear pulses for served hall calls.
REQ-011 SHALL have port current_level output $clog2(BUTTONS_WIDTH): cab position.
REQ-012 SHALL have ports motor_up output 1, motor_down output 1 and door_open output 1.
REQ-013 SHALL have port dir_up output 1: travel preference (1 = up).

Function
REQ-014 SHALL drive all outputs from registers; every transition below takes effect on the next clk edge.
REQ-015 SHALL implement the FSM states IDLE, MOVING, ARRIVE and DOORS.
REQ-016 SHALL compute, combinationally: req_any[i] = OR of the three active vectors at level i; ahead = any req_any bit beyond current_level in dir_up direction; behind = any bit in the opposite direction.
REQ-017 SHALL, in IDLE: if req_any[current_level], go to DOORS; else if ahead, go to MOVING; else if behind, toggle dir_up and go to MOVING; else stay in IDLE.
REQ-018 SHALL, in MOVING: assert motor_up = dir_up and motor_down = !dir_up; count TRAVEL_CYCLES; on the terminal count, step current_level by ±1, deassert the motor and go to ARRIVE.
REQ-019 SHALL define a stop at level L (going up) as active_in[L] | active_out_up[L] | (active_out_down[L] & !ahead); going down is the mirror.
REQ-020 SHALL, in ARRIVE: if stop, go to DOORS; else if ahead, go to MOVING; else if behind, toggle dir_up and go to MOVING; else go to IDLE.
REQ-021 SHALL, on entry to DOORS: assert door_open; pulse inactivate_in_levels[L]; pulse the hall-call clear for dir_up at L. If !ahead, also pulse the opposite hall clear and toggle dir_up.
REQ-022 SHALL hold door_open for DOOR_CYCLES, then go to IDLE.
REQ-023 SHALL, if any active bit at current_level rises while in DOORS, pulse its clear and restart the door count (door hold).
REQ-024 SHALL keep current_level within 0..BUTTONS_WIDTH-1 and SHALL force dir_up=0 at the top level and dir_up=1 at level 0.
REQ-025 SHALL never assert motor_up and motor_down together, and SHALL never assert either motor while door_open=1.
REQ-026 SHALL make every inactivate bit exactly one cycle wide, with at most one level's bits set at a time.

Reset
REQ-027 SHALL, while reset=1, asynchronously force: state IDLE, current_level 0, dir_up 1, timer 0, motors 0, door_open 0, all inactivate outputs 0.
REQ-028 SHALL, on reset mid-move, not complete the interrupted level step.

Structure
REQ-029 SHALL place the FSM state encoding and the default parameter values in a shared package, elevator_pkg.
REQ-030 SHALL use one sub-module, lift_timer: a loadable down-counter with a done flag, shared by MOVING and DOORS.

Verification (bench: BUTTONS_WIDTH=8, TRAVEL_CYCLES=4, DOOR_CYCLES=3)
REQ-031 SHALL cover: assert reset -> all outputs 0, current_level 0, dir_up 1, with no clk edge required.
REQ-032 SHALL cover: at level 0, active_in_levels=8'h08 -> motor_up for 12 cycles, current_level=3, door_open for 3 cycles, inactivate_in_levels=8'h08 for one cycle.
REQ-033 SHALL cover: at level 0, up calls at levels 4 and 5 plus down call at level 7 -> stops at 4, 5, 7 in order; at 7, inactivate_out_down_levels=8'h80 and dir_up becomes 0.
REQ-034 SHALL cover: idle at level 2, active_out_down_levels=8'h04 -> DOORS within 1 cycle, matching clear pulse, no motor activity.
REQ-035 SHALL cover: during DOORS at level 3, raise active_in_levels[3] on the second door cycle -> second clear pulse, and door_open stays high 3 cycles past the re-press.
REQ-036 SHALL cover: assert reset during MOVING -> motors drop immediately, and current_level returns to 0.

Source files
------------

// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared FSM encoding and default sizing for the car scheduler
// Contents: default parameter values and the state constants used by car_scheduler.
package elevator_pkg;

    localparam int DEF_BUTTONS_WIDTH = 8;
    localparam int DEF_TRAVEL_CYCLES = 16;
    localparam int DEF_DOOR_CYCLES   = 32;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_MOVING = 2'd1;
    localparam logic [1:0] ST_ARRIVE = 2'd2;
    localparam logic [1:0] ST_DOORS  = 2'd3;

endpackage

// File: rtl/lift_timer.sv
// rtl/lift_timer.sv - loadable down-counter with done flag, shared by travel and door timing
// Ports: clk, reset (async, active-high), load/load_value (reload counter), done (count is zero).
module lift_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             done
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/car_scheduler.sv
// rtl/car_scheduler.sv - single-car elevator scheduler (collective sweep in current direction)
// Inputs : clk, reset (async, active-high), latched car calls and up/down hall calls per level.
// Outputs: one-cycle clear pulses per call vector, current_level, motor_up/motor_down,
//          door_open, dir_up. All outputs are registered.
module car_scheduler
    import elevator_pkg::*;
#(
    parameter int BUTTONS_WIDTH = DEF_BUTTONS_WIDTH,
    parameter int TRAVEL_CYCLES = DEF_TRAVEL_CYCLES,
    parameter int DOOR_CYCLES   = DEF_DOOR_CYCLES
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [BUTTONS_WIDTH-1:0]         active_in_levels,
    input  logic [BUTTONS_WIDTH-1:0]         active_out_up_levels,
    input  logic [BUTTONS_WIDTH-1:0]         active_out_down_levels,
    output logic [BUTTONS_WIDTH-1:0]         inactivate_in_levels,
    output logic [BUTTONS_WIDTH-1:0]         inactivate_out_up_levels,
    output logic [BUTTONS_WIDTH-1:0]         inactivate_out_down_levels,
    output logic [$clog2(BUTTONS_WIDTH)-1:0] current_level,
    output logic                             motor_up,
    output logic                             motor_down,
    output logic                             door_open,
    output logic                             dir_up
);

    localparam int LW        = $clog2(BUTTONS_WIDTH);
    localparam int MAX_COUNT = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int TW        = $clog2(MAX_COUNT + 1);

    localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
    localparam logic [TW-1:0] DOOR_LOAD   = TW'(DOOR_CYCLES - 1);
    localparam logic [LW-1:0] TOP_LEVEL   = LW'(BUTTONS_WIDTH - 1);

    logic [1:0]               state, state_n;
    logic [LW-1:0]            level_n;
    logic                     dir_n, motor_up_n, motor_down_n, door_n;
    logic [BUTTONS_WIDTH-1:0] clr_in_n, clr_up_n, clr_down_n;
    logic [BUTTONS_WIDTH-1:0] prev_in, prev_up, prev_down;
    logic [BUTTONS_WIDTH-1:0] req_any, level_bit, mask_below, mask_above;
    logic [BUTTONS_WIDTH-1:0] rise_in, rise_up, rise_down;
    logic                     any_above, any_below, ahead, behind;
    logic                     at_in, at_up, at_down, req_here, hall_dir_here, hall_opp_here, stop;
    logic                     serve_dir, serve_ahead, move_dir;
    logic                     timer_load, timer_done;
    logic [TW-1:0]            timer_value;

    assign req_any    = active_in_levels | active_out_up_levels | active_out_down_levels;
    assign level_bit  = BUTTONS_WIDTH'(1) << current_level;
    assign mask_below = level_bit - BUTTONS_WIDTH'(1);
    assign mask_above = ~(mask_below | level_bit);
    assign any_above  = |(req_any & mask_above);
    assign any_below  = |(req_any & mask_below);
    assign ahead      = dir_up ? any_above : any_below;
    assign behind     = dir_up ? any_below : any_above;

    assign at_in         = |(active_in_levels & level_bit);
    assign at_up         = |(active_out_up_levels & level_bit);
    assign at_down       = |(active_out_down_levels & level_bit);
    assign req_here      = at_in | at_up | at_down;
    assign hall_dir_here = dir_up ? at_up : at_down;
    assign hall_opp_here = dir_up ? at_down : at_up;
    // An opposite-direction hall call only stops the car once the sweep has nothing further ahead.
    assign stop          = at_in | hall_dir_here | (hall_opp_here & ~ahead);

    // Calls at the current level that appeared since last cycle; these extend an open door.
    assign rise_in   = active_in_levels & ~prev_in & level_bit;
    assign rise_up   = active_out_up_levels & ~prev_up & level_bit;
    assign rise_down = active_out_down_levels & ~prev_down & level_bit;

    always_comb begin
        state_n      = state;
        level_n      = current_level;
        dir_n        = dir_up;
        motor_up_n   = 1'b0;
        motor_down_n = 1'b0;
        door_n       = door_open;
        clr_in_n     = '0;
        clr_up_n     = '0;
        clr_down_n   = '0;
        timer_load   = 1'b0;
        timer_value  = TRAVEL_LOAD;
        // When idle with only an opposite hall call here (and work ahead), serve it as if
        // facing the other way; otherwise the car would reopen its doors forever.
        serve_dir    = stop ? dir_up : ~dir_up;
        serve_ahead  = stop ? ahead : behind;
        move_dir     = ahead ? dir_up : ~dir_up;

        case (state)
            ST_IDLE, ST_ARRIVE: begin
                if ((state == ST_IDLE && req_here) || (state == ST_ARRIVE && stop)) begin
                    state_n     = ST_DOORS;
                    door_n      = 1'b1;
                    clr_in_n    = level_bit;
                    clr_up_n    = (serve_dir || !serve_ahead) ? level_bit : '0;
                    clr_down_n  = (!serve_dir || !serve_ahead) ? level_bit : '0;
                    dir_n       = serve_ahead ? serve_dir : ~serve_dir;
                    timer_load  = 1'b1;
                    timer_value = DOOR_LOAD;
                end else if (ahead || behind) begin
                    state_n      = ST_MOVING;
                    motor_up_n   = move_dir;
                    motor_down_n = ~move_dir;
                    dir_n        = move_dir;
                    timer_load   = 1'b1;
                    timer_value  = TRAVEL_LOAD;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_MOVING: begin
                if (timer_done) begin
                    state_n = ST_ARRIVE;
                    if (motor_up && current_level != TOP_LEVEL) begin
                        level_n = current_level + LW'(1);
                    end else if (motor_down && current_level != '0) begin
                        level_n = current_level - LW'(1);
                    end
                end else begin
                    motor_up_n   = motor_up;
                    motor_down_n = motor_down;
                end
            end
            ST_DOORS: begin
                if (|(rise_in | rise_up | rise_down)) begin
                    clr_in_n    = rise_in;
                    clr_up_n    = rise_up;
                    clr_down_n  = rise_down;
                    timer_load  = 1'b1;
                    timer_value = DOOR_LOAD;
                end else if (timer_done) begin
                    door_n  = 1'b0;
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                      <= ST_IDLE;
            current_level              <= '0;
            dir_up                     <= 1'b1;
            motor_up                   <= 1'b0;
            motor_down                 <= 1'b0;
            door_open                  <= 1'b0;
            inactivate_in_levels       <= '0;
            inactivate_out_up_levels   <= '0;
            inactivate_out_down_levels <= '0;
            prev_in                    <= '0;
            prev_up                    <= '0;
            prev_down                  <= '0;
        end else begin
            state                      <= state_n;
            current_level              <= level_n;
            // End levels pin the direction so the car can never point off the shaft.
            dir_up                     <= (level_n == TOP_LEVEL) ? 1'b0 :
                                          (level_n == '0)        ? 1'b1 : dir_n;
            motor_up                   <= motor_up_n;
            motor_down                 <= motor_down_n;
            door_open                  <= door_n;
            inactivate_in_levels       <= clr_in_n;
            inactivate_out_up_levels   <= clr_up_n;
            inactivate_out_down_levels <= clr_down_n;
            prev_in                    <= active_in_levels;
            prev_up                    <= active_out_up_levels;
            prev_down                  <= active_out_down_levels;
        end
    end

    lift_timer #(
        .WIDTH(TW)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (timer_load),
        .load_value (timer_value),
        .done       (timer_done)
    );

endmodule

// File: tb/tb_car_scheduler.sv
// tb/tb_car_scheduler.sv - self-checking bench for car_scheduler
module tb_car_scheduler;

    localparam int W = 8;
    localparam int T = 4;
    localparam int D = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] in_l, up_l, dn_l;
    logic [W-1:0] clr_in, clr_up, clr_dn;
    logic [2:0]   level;
    logic         mu, md, door, dir;
    int           checks = 0;
    int           failures = 0;

    car_scheduler #(
        .BUTTONS_WIDTH(W),
        .TRAVEL_CYCLES(T),
        .DOOR_CYCLES  (D)
    ) dut (
        .clk                        (clk),
        .reset                      (reset),
        .active_in_levels           (in_l),
        .active_out_up_levels       (up_l),
        .active_out_down_levels     (dn_l),
        .inactivate_in_levels       (clr_in),
        .inactivate_out_up_levels   (clr_up),
        .inactivate_out_down_levels (clr_dn),
        .current_level              (level),
        .motor_up                   (mu),
        .motor_down                 (md),
        .door_open                  (door),
        .dir_up                     (dir)
    );

    always #5 clk = ~clk;

    // One clock: sample after the edge, then behave like the call latches (clear on pulse).
    task automatic step();
        @(posedge clk);
        #1;
        in_l = in_l & ~clr_in;
        up_l = up_l & ~clr_up;
        dn_l = dn_l & ~clr_dn;
    endtask

    task automatic do_reset();
        in_l  = '0;
        up_l  = '0;
        dn_l  = '0;
        reset = 1'b1;
        #3;
        reset = 1'b0;
        step();
    endtask

    task automatic test_reset();
        in_l  = '0;
        up_l  = '0;
        dn_l  = '0;
        reset = 1'b1;
        #1;
        checks++; if (level !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
        checks++; if (dir !== 1'b1) begin failures++; $display("FAIL reset_dir got=%b exp=1", dir); end
        checks++; if ({mu, md, door} !== 3'b000) begin failures++; $display("FAIL reset_motor_door got=%b exp=000", {mu, md, door}); end
        checks++; if ({clr_in, clr_up, clr_dn} !== 24'h0) begin failures++; $display("FAIL reset_clears got=%h exp=0", {clr_in, clr_up, clr_dn}); end
        #2;
        reset = 1'b0;
        step();
    endtask

    task automatic test_car_call();
        int mu_cnt = 0, md_cnt = 0, door_cnt = 0, pulse_cnt = 0, door_level = -1, cyc = 0;
        bit opened = 0;
        do_reset();
        in_l = 8'h08;
        while (cyc < 200 && !(opened && !door)) begin
            step();
            cyc++;
            if (mu) mu_cnt++;
            if (md) md_cnt++;
            if (clr_in == 8'h08) pulse_cnt++;
            if (door) begin
                if (!opened) door_level = int'(level);
                opened = 1;
                door_cnt++;
            end
        end
        checks++; if (cyc >= 200) begin failures++; $display("FAIL car_call_timeout got=%0d exp<200", cyc); end
        checks++; if (mu_cnt != 12) begin failures++; $display("FAIL car_call_motor_up got=%0d exp=12", mu_cnt); end
        checks++; if (md_cnt != 0) begin failures++; $display("FAIL car_call_motor_down got=%0d exp=0", md_cnt); end
        checks++; if (door_level != 3) begin failures++; $display("FAIL car_call_level got=%0d exp=3", door_level); end
        checks++; if (door_cnt != D) begin failures++; $display("FAIL car_call_door_cycles got=%0d exp=%0d", door_cnt, D); end
        checks++; if (pulse_cnt != 1) begin failures++; $display("FAIL car_call_clear_pulses got=%0d exp=1", pulse_cnt); end
    endtask

    task automatic test_multi_stop();
        int stops[$];
        int exp_stops[3] = '{4, 5, 7};
        int cyc = 0, got;
        bit prev_door = 0;
        logic [W-1:0] dn_at7 = '0;
        logic dir_at7 = 1'b1;
        do_reset();
        up_l = 8'h30;
        dn_l = 8'h80;
        while (cyc < 400 && !(in_l == '0 && up_l == '0 && dn_l == '0 && !door && !mu && !md)) begin
            step();
            cyc++;
            if (door && !prev_door) begin
                stops.push_back(int'(level));
                if (level == 3'd7) begin
                    dn_at7  = clr_dn;
                    dir_at7 = dir;
                end
            end
            prev_door = door;
        end
        checks++; if (stops.size() != 3) begin failures++; $display("FAIL multi_stop_count got=%0d exp=3", stops.size()); end
        for (int i = 0; i < 3; i++) begin
            got = (i < stops.size()) ? stops[i] : -1;
            checks++; if (got != exp_stops[i]) begin failures++; $display("FAIL multi_stop_order[%0d] got=%0d exp=%0d", i, got, exp_stops[i]); end
        end
        checks++; if (dn_at7 !== 8'h80) begin failures++; $display("FAIL multi_stop_down_clear got=%h exp=80", dn_at7); end
        checks++; if (dir_at7 !== 1'b0) begin failures++; $display("FAIL multi_stop_dir got=%b exp=0", dir_at7); end
    endtask

    task automatic test_idle_hall_call();
        int cyc = 0;
        bit opened = 0, motor_seen = 0;
        do_reset();
        in_l = 8'h04;
        while (cyc < 200 && !(opened && !door)) begin
            step();
            cyc++;
            if (door) opened = 1;
        end
        checks++; if (level !== 3'd2) begin failures++; $display("FAIL idle_hall_setup_level got=%0d exp=2", level); end
        dn_l = 8'h04;
        step();
        checks++; if (door !== 1'b1) begin failures++; $display("FAIL idle_hall_door got=%b exp=1", door); end
        checks++; if (clr_dn !== 8'h04) begin failures++; $display("FAIL idle_hall_clear got=%h exp=04", clr_dn); end
        cyc = 0;
        while (cyc < 50 && door) begin
            if (mu || md) motor_seen = 1;
            step();
            cyc++;
        end
        checks++; if (motor_seen || door) begin failures++; $display("FAIL idle_hall_motion got=%b door=%b exp=0", motor_seen, door); end
    endtask

    task automatic test_door_hold();
        int cyc = 0, held = 0, second_pulse = 0;
        do_reset();
        in_l = 8'h08;
        while (cyc < 200 && !door) begin
            step();
            cyc++;
        end
        checks++; if (!(door === 1'b1 && level === 3'd3)) begin failures++; $display("FAIL door_hold_arrive got=%b/%0d exp=1/3", door, level); end
        step();
        checks++; if (door !== 1'b1) begin failures++; $display("FAIL door_hold_second_cycle got=%b exp=1", door); end
        in_l = in_l | 8'h08;
        cyc = 0;
        while (cyc < 50) begin
            step();
            cyc++;
            if (clr_in == 8'h08) second_pulse++;
            if (!door) break;
            held++;
        end
        checks++; if (second_pulse != 1) begin failures++; $display("FAIL door_hold_pulse got=%0d exp=1", second_pulse); end
        checks++; if (held != D) begin failures++; $display("FAIL door_hold_cycles got=%0d exp=%0d", held, D); end
    endtask

    task automatic test_reset_moving();
        int cyc = 0;
        do_reset();
        in_l = 8'h80;
        while (cyc < 100 && !(level == 3'd2 && mu)) begin
            step();
            cyc++;
        end
        checks++; if (!(level === 3'd2 && mu === 1'b1)) begin failures++; $display("FAIL reset_moving_setup got=%0d/%b exp=2/1", level, mu); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if ({mu, md} !== 2'b00) begin failures++; $display("FAIL reset_moving_motors got=%b exp=00", {mu, md}); end
        checks++; if (level !== 3'd0) begin failures++; $display("FAIL reset_moving_level got=%0d exp=0", level); end
        in_l  = '0;
        reset = 1'b0;
        step();
        step();
        checks++; if ({level, mu, md} !== 5'b0) begin failures++; $display("FAIL reset_moving_after got=%0d/%b%b exp=0/00", level, mu, md); end
    endtask

    // Random calls; the model tracks position as accumulated motor time and checks safety rules.
    task automatic test_random();
        int cyc = 0, model_level = 0, up_run = 0, dn_run = 0, b, k;
        bit drained = 0;
        logic [W-1:0] mask, pv;
        logic [3*W-1:0] prev_p = '0;
        do_reset();
        while (cyc < 6000 && !drained) begin
            step();
            cyc++;
            checks++; if (mu && md) begin failures++; $display("FAIL rand_both_motors cyc=%0d got=11 exp=not both", cyc); end
            checks++; if ((mu || md) && door) begin failures++; $display("FAIL rand_motor_with_door cyc=%0d got=1 exp=0", cyc); end
            if (mu) begin
                up_run++;
                if (up_run == T) begin model_level++; up_run = 0; end
            end
            if (md) begin
                dn_run++;
                if (dn_run == T) begin model_level--; dn_run = 0; end
            end
            if (!mu && !md) begin
                checks++; if (int'(level) != model_level) begin failures++; $display("FAIL rand_level cyc=%0d got=%0d exp=%0d", cyc, level, model_level); end
            end
            pv = clr_in | clr_up | clr_dn;
            if (pv != '0) begin
                checks++; if (pv != (8'd1 << level) || !door) begin failures++; $display("FAIL rand_pulse_level cyc=%0d got=%h exp=%h", cyc, pv, 8'd1 << level); end
            end
            checks++; if (({clr_in, clr_up, clr_dn} & prev_p) != '0) begin failures++; $display("FAIL rand_pulse_width cyc=%0d got=%h exp=0", cyc, {clr_in, clr_up, clr_dn} & prev_p); end
            prev_p = {clr_in, clr_up, clr_dn};
            if (level == 3'd7) begin
                checks++; if (dir !== 1'b0) begin failures++; $display("FAIL rand_dir_top got=%b exp=0", dir); end
            end
            if (level == 3'd0) begin
                checks++; if (dir !== 1'b1) begin failures++; $display("FAIL rand_dir_bottom got=%b exp=1", dir); end
            end
            if (cyc < 3000) begin
                if ($urandom_range(0, 7) == 0) begin
                    b    = $urandom_range(0, W - 1);
                    k    = $urandom_range(0, 2);
                    mask = 8'd1 << b;
                    if (k == 0 && (clr_in & mask) == '0) in_l = in_l | mask;
                    if (k == 1 && (clr_up & mask) == '0) up_l = up_l | mask;
                    if (k == 2 && (clr_dn & mask) == '0) dn_l = dn_l | mask;
                end
            end else if (in_l == '0 && up_l == '0 && dn_l == '0 && !door && !mu && !md) begin
                drained = 1;
            end
        end
        checks++; if (!drained) begin failures++; $display("FAIL rand_drain got=%h/%h/%h exp=all served", in_l, up_l, dn_l); end
    endtask

    initial begin
        test_reset();
        test_car_call();
        test_multi_stop();
        test_idle_hall_call();
        test_door_hold();
        test_reset_moving();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
